// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// No logic; constants only.
// Imported by rst_sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT = 3'd0,
        SEQ    = 3'd1,
        RUN    = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } rst_seq_state_e;

    localparam int STAT_W = 8;

    // Counter must hold the larger of the two stage lengths without wrapping.
    function automatic int CNT_W(input int stage_dly, input int soft_hold);
        int m;
        m = (stage_dly > soft_hold) ? stage_dly : soft_hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset deassertion synchronizer: assertion is immediate, release takes SYNC_STAGES edges.
// Latency: SYNC_STAGES rising edges from reset_n release to sync_rst_n high.
// Backpressure: none.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic sync_rst_n
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Releases NUM_OUT downstream resets in ascending order, STAGE_DLY edges apart; soft reset via 4-phase req/ack.
// Latency: bit i rises SYNC_STAGES + (i+1)*STAGE_DLY edges after reset_n release (SOFT_HOLD + (i+1)*STAGE_DLY after a soft request).
// Backpressure: soft_rst_req is only sampled in RUN; ack holds until req drops. RST_SEQ_STATUS_EN adds soft_rst_cnt.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_OUT     = 4,
    parameter int STAGE_DLY   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int SOFT_HOLD   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               soft_rst_req,
    output logic               soft_rst_ack,
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               all_released,
`ifdef RST_SEQ_STATUS_EN
    output logic [STAT_W-1:0]  soft_rst_cnt,
`endif
    output logic               busy
);

    localparam int CW    = CNT_W(STAGE_DLY, SOFT_HOLD);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CW-1:0]    STAGE_LAST = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0]    HOLD_LAST  = CW'(SOFT_HOLD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OUT - 1);

    logic sync_rst_n;

    rst_seq_state_e     state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      seq_cnt;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic               soft_q, soft_d;

    rst_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_rst_n (sync_rst_n)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            soft_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            soft_q  <= soft_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        soft_d  = soft_q;
        // The edge that first sees sync_rst_n high is the first delay cycle of stage 0.
        seq_cnt = (state_q == ASSERT) ? '0 : cnt_q;

        case (state_q)
            ASSERT, SEQ: begin
                if (state_q == SEQ || sync_rst_n) begin
                    if (seq_cnt == STAGE_LAST) begin
                        out_d[idx_q] = 1'b1;
                        cnt_d        = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = soft_q ? DONE : RUN;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = SEQ;
                        end
                    end else begin
                        cnt_d   = seq_cnt + CW'(1);
                        state_d = SEQ;
                    end
                end
            end
            RUN: begin
                if (soft_rst_req) begin
                    state_d = HOLD;
                    out_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    soft_d  = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!soft_rst_req) begin
                    state_d = RUN;
                    soft_d  = 1'b0;
                end
            end
            default: begin
                state_d = ASSERT;
            end
        endcase
    end

    assign rst_n_out    = out_q;
    assign all_released = &out_q;
    assign busy         = (state_q != RUN);
    assign soft_rst_ack = (state_q == DONE);

`ifdef RST_SEQ_STATUS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_q <= '0;
        end else if (state_q != DONE && state_d == DONE && stat_q != {STAT_W{1'b1}}) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign soft_rst_cnt = stat_q;
`endif

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Synthesizable consumer of the bench-generated `clk`/`reset_n` pair. It:
- synchronizes deassertion of the asynchronous active-low `reset_n`;
- releases `NUM_OUT` downstream block resets one after another at fixed cycle spacing;
- services a 4-phase soft-reset request handshake that re-runs the release sequence without external `reset_n`.

It sits between the top-level clock/reset interface and the DUT subsystems' reset inputs.

## Interface
Parameters:
- `NUM_OUT`, 4: number of sequenced reset outputs (1..16).
- `STAGE_DLY`, 16: clock cycles between successive releases (≥1).
- `SYNC_STAGES`, 2: reset deassertion synchronizer depth (≥2).
- `SOFT_HOLD`, 8: cycles all outputs stay asserted during a soft reset (≥1).

Ports:
- `clk`, input, 1: the single clock; all state is on its rising edge.
- `reset_n`, input, 1: asynchronous active-low reset. Assertion acts immediately; deassertion is synchronized.
- `soft_rst_req`, input, 1: level request for a soft reset (4-phase).
- `soft_rst_ack`, output, 1: soft-reset completion acknowledge.
- `rst_n_out`, output, `NUM_OUT`: active-low downstream resets. Bit 0 is released first.
- `all_released`, output, 1: high when every `rst_n_out` bit is high.
- `busy`, output, 1: high in any state other than RUN.

## Operation
- Reset values while `reset_n` is low: `rst_n_out`=0, `all_released`=0, `soft_rst_ack`=0, `busy`=1, state ASSERT, counters 0. Outputs clear asynchronously.
- States and transitions:
  - ASSERT: waits for synchronized reset `sync_rst_n`=1, then goes to SEQ. The stage counter loads 0 and the release index loads 0.
  - SEQ: counts `STAGE_DLY` cycles, then sets `rst_n_out[idx]`=1, increments `idx` and reloads the counter. After bit `NUM_OUT-1` is released:
    - go to DONE if the sequence was soft-initiated;
    - otherwise go to RUN.
  - RUN: `busy`=0. If `soft_rst_req`=1 is sampled, go to HOLD; all `rst_n_out` are driven to 0 on that same edge.
  - HOLD: counts `SOFT_HOLD` cycles, then goes to SEQ with `idx`=0.
  - DONE: `soft_rst_ack`=1 and outputs stay released. When `soft_rst_req`=0 is sampled, `ack` drops on that edge and the state goes to RUN.
- `soft_rst_req` is ignored in ASSERT, SEQ and HOLD. A request still high on entering RUN is honoured on the first RUN edge.
- A new request cannot start while `ack` is high.
- `reset_n` asserting in any state, including mid-SEQ or mid-HOLD, aborts immediately and goes to ASSERT. No `ack` is generated.
- The release order is strictly ascending. Released bits never glitch low except on soft reset or `reset_n`.
- Counter width is `$clog2(max(STAGE_DLY, SOFT_HOLD)+1)`. Counters do not wrap within a stage.

## Timing
- `sync_rst_n` rises on rising edge `SYNC_STAGES` after `reset_n` rises. Edge 1 is the first edge with `reset_n` high.
- `rst_n_out[i]` rises on edge `SYNC_STAGES + (i+1)*STAGE_DLY`.
  - With defaults: edges 18, 34, 50, 66.
- `all_released` rises on the same edge as the last bit.
- Soft reset with request sampled at edge E:
  - all outputs fall on edge E;
  - `rst_n_out[i]` rises on edge `E + SOFT_HOLD + (i+1)*STAGE_DLY`;
  - `soft_rst_ack` rises with `all_released`.
- `ack` falls on the first edge sampling `req`=0. `busy` falls on that same edge.

## Configuration
- `RST_SEQ_STATUS_EN` defined:
  - adds output `soft_rst_cnt` (8 bits), a saturating count of completed soft resets;
  - it increments on DONE entry, holds at 255, and is cleared only by `reset_n`.
- `RST_SEQ_STATUS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package `rst_seq_pkg`:
  - state enum `rst_seq_state_e` (ASSERT, SEQ, RUN, HOLD, DONE);
  - `CNT_W` helper function;
  - status counter width constant (8).
- Sub-module `rst_sync`: `SYNC_STAGES`-deep flop chain with asynchronous clear by `reset_n`, D tied high. It produces `sync_rst_n`.

## Test plan
- Power-on, defaults: `reset_n` low for 5 cycles then high → `rst_n_out` is 0000 until edge 18, then 0001@18, 0011@34, 0111@50, 1111@66. `all_released` and `busy`=0 at edge 66.
- Reset mid-sequence: drop `reset_n` at edge 40 → `rst_n_out`=0000 with no clock edge. After re-release, the full timing repeats from edge 1.
- Soft reset: `req`=1 at edge 100 in RUN → outputs 0000@100, bit 0 up @124 (100+8+16), all up @172 with `ack`=1. Drop `req` → `ack`=0 and `busy`=0 on the next edge.
- Request during SEQ: `req` high from edge 20 → no effect until RUN at 66. HOLD is entered at edge 67.
- `reset_n` pulse while `ack`=1 → `ack`=0 and `rst_n_out`=0 asynchronously. No `ack` after the sequence completes.
- With `RST_SEQ_STATUS_EN`, `NUM_OUT`=1, `STAGE_DLY`=1, `SOFT_HOLD`=1: 260 soft resets → `soft_rst_cnt` ends at 255. The single bit rises 2 edges after each request.
